// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
// Build option: define RF_BYPASS_EN for same-cycle write-to-read forwarding.
package rf_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  // Register 0 is the hardwired-zero register.
  localparam int unsigned REG_ZERO = 0;

  typedef logic [AW_DEFAULT-1:0]   reg_idx_t;
  typedef logic [XLEN_DEFAULT-1:0] word_t;

endpackage : rf_pkg

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file.
// The master modport is the datapath side; the slave modport is the register file.
interface regfile_mp_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NR    = 2,
  parameter int unsigned NW    = 1
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NW-1:0]            we;
  logic [NW-1:0][AW-1:0]    wa;
  logic [NW-1:0][XLEN-1:0]  wd;
  logic [NR-1:0][AW-1:0]    ra;
  logic [NR-1:0][XLEN-1:0]  rd;
  logic [NR-1:0]            rbusy;
  logic                     alloc_en;
  logic [AW-1:0]            alloc_addr;

  modport master (
    output we, wa, wd, ra, alloc_en, alloc_addr,
    input  rd, rbusy
  );

  modport slave (
    input  we, wa, wd, ra, alloc_en, alloc_addr,
    output rd, rbusy
  );

endinterface : regfile_mp_if

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register, set by allocation,
// cleared by a committed write; a same-cycle allocation beats the clear.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned NW    = 1,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  input  logic [NW-1:0]          wr_en,
  input  logic [NW-1:0][AW-1:0]  wr_addr,
  output logic [NREGS-1:0]       busy
);

  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_q;

  // NOTE: blocking assignments in always_comb run in order, so the later
  // statement (the allocation) overrides an earlier clear of the same bit.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (wr_en[j] && (wr_addr[j] != AW'(REG_ZERO))) begin
        busy_d[wr_addr[j]] = 1'b0;
      end
    end
    if (alloc_en && (alloc_addr != AW'(REG_ZERO))) begin
      busy_d[alloc_addr] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule : rf_scoreboard

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with collision priority and
// pending-writeback scoreboard. Build option: RF_BYPASS_EN adds wd->rd forwarding.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned NR    = 2,
  parameter int unsigned NW    = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_d [NREGS];
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;

  // Ascending port order: the highest-indexed writer to an address lands last.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NW; j++) begin
      if (bus.we[j] && (bus.wa[j] != AW'(REG_ZERO))) begin
        regs_d[bus.wa[j]] = bus.wd[j];
      end
    end
    regs_d[REG_ZERO] = '0;
  end

  // NOTE: the whole array is reset here, which forces it into flops rather
  // than a RAM macro; a synchronous clear of every register is required.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NW    (NW),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .wr_en      (bus.we),
    .wr_addr    (bus.wa),
    .busy       (busy)
  );

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      bus.rd[i]    = regs_q[bus.ra[i]];
      bus.rbusy[i] = busy[bus.ra[i]];
`ifdef RF_BYPASS_EN
      for (int j = 0; j < NW; j++) begin
        if (bus.we[j] && (bus.wa[j] == bus.ra[i]) && (bus.ra[i] != AW'(REG_ZERO))) begin
          bus.rd[i]    = bus.wd[j];
          bus.rbusy[i] = 1'b0;
        end
      end
`endif
      if (bus.ra[i] == AW'(REG_ZERO)) begin
        bus.rd[i]    = '0;
        bus.rbusy[i] = 1'b0;
      end
    end
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NR=2, NW=2) against an array-based model.
module tb_regfile_mp;
  import rf_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NR    = 2;
  localparam int unsigned NW    = 2;

  logic clk;
  logic reset;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_regs [NREGS];
  bit          model_busy [NREGS];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    bit written [NREGS];
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        model_regs[r] = 32'h0;
        model_busy[r] = 1'b0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) written[r] = 1'b0;
      // Highest port wins: scan from the top and let the first claim stick.
      for (int j = NW - 1; j >= 0; j--) begin
        int a;
        a = int'(bus.wa[j]);
        if (bus.we[j] && a != 0 && !written[a]) begin
          model_regs[a] = bus.wd[j];
          written[a]    = 1'b1;
        end
      end
      for (int r = 1; r < NREGS; r++) begin
        if (written[r]) model_busy[r] = 1'b0;
      end
      if (bus.alloc_en && bus.alloc_addr != 0) model_busy[int'(bus.alloc_addr)] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_rd(int i);
    int a;
    a = int'(bus.ra[i]);
    if (a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
    for (int j = NW - 1; j >= 0; j--) begin
      if (bus.we[j] && int'(bus.wa[j]) == a) return bus.wd[j];
    end
`endif
    return model_regs[a];
  endfunction

  function automatic logic exp_busy(int i);
    int a;
    a = int'(bus.ra[i]);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    for (int j = 0; j < NW; j++) begin
      if (bus.we[j] && int'(bus.wa[j]) == a) return 1'b0;
    end
`endif
    return model_busy[a];
  endfunction

  task automatic idle_inputs();
    bus.we         = '0;
    bus.wa         = '0;
    bus.wd         = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.ra = '0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    bus.ra[0] = 5'd1;
    bus.ra[1] = 5'd31;
    #1;
    for (int i = 0; i < NR; i++) begin
      tests_run++;
      if (bus.rd[i] !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_rd[%0d]: got %h required %h", i, bus.rd[i], 32'h0);
      end
      tests_run++;
      if (bus.rbusy[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_rbusy[%0d]: got %b required 0", i, bus.rbusy[i]);
      end
    end
  endtask

  task automatic test_basic();
    bus.we[0] = 1'b1; bus.wa[0] = 5'd5; bus.wd[0] = 32'h0000_5555;
    tick();
    idle_inputs();
    bus.ra[0] = 5'd5;
    #1;
    tests_run++;
    if (bus.rd[0] !== 32'h0000_5555) begin
      tests_failed++;
      $display("FAIL basic_rd5: got %h required %h", bus.rd[0], 32'h0000_5555);
    end
    bus.we[0] = 1'b1; bus.wa[0] = 5'd0; bus.wd[0] = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    bus.ra[1] = 5'd0;
    #1;
    tests_run++;
    if (bus.rd[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL basic_rd0: got %h required %h", bus.rd[1], 32'h0);
    end
  endtask

  task automatic test_collision();
    bus.we = 2'b11;
    bus.wa[0] = 5'd7; bus.wd[0] = 32'hAAAA_AAAA;
    bus.wa[1] = 5'd7; bus.wd[1] = 32'hBBBB_BBBB;
    tick();
    idle_inputs();
    bus.ra[0] = 5'd7;
    #1;
    tests_run++;
    if (bus.rd[0] !== 32'hBBBB_BBBB) begin
      tests_failed++;
      $display("FAIL collision_same: got %h required %h", bus.rd[0], 32'hBBBB_BBBB);
    end
    bus.we = 2'b11;
    bus.wa[0] = 5'd3; bus.wd[0] = 32'h0303_0303;
    bus.wa[1] = 5'd4; bus.wd[1] = 32'h0404_0404;
    tick();
    idle_inputs();
    bus.ra[0] = 5'd3;
    bus.ra[1] = 5'd4;
    #1;
    tests_run++;
    if (bus.rd[0] !== 32'h0303_0303) begin
      tests_failed++;
      $display("FAIL collision_diff3: got %h required %h", bus.rd[0], 32'h0303_0303);
    end
    tests_run++;
    if (bus.rd[1] !== 32'h0404_0404) begin
      tests_failed++;
      $display("FAIL collision_diff4: got %h required %h", bus.rd[1], 32'h0404_0404);
    end
  endtask

  task automatic test_scoreboard();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
    tick();
    idle_inputs();
    bus.ra[0] = 5'd9;
    #1;
    tests_run++;
    if (bus.rbusy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_alloc: got %b required 1", bus.rbusy[0]);
    end
    bus.we[1] = 1'b1; bus.wa[1] = 5'd9; bus.wd[1] = 32'h0000_0909;
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (bus.rbusy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_clear: got %b required 0", bus.rbusy[0]);
    end
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
    bus.we[0] = 1'b1; bus.wa[0] = 5'd9; bus.wd[0] = 32'h0000_9999;
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (bus.rbusy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_alloc_wins: got %b required 1", bus.rbusy[0]);
    end
    tests_run++;
    if (bus.rd[0] !== 32'h0000_9999) begin
      tests_failed++;
      $display("FAIL sb_alloc_wins_rd: got %h required %h", bus.rd[0], 32'h0000_9999);
    end
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0;
    tick();
    idle_inputs();
    bus.ra[1] = 5'd0;
    #1;
    tests_run++;
    if (bus.rbusy[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_alloc0: got %b required 0", bus.rbusy[1]);
    end
  endtask

  task automatic test_bypass();
    bus.we[0] = 1'b1; bus.wa[0] = 5'd12; bus.wd[0] = 32'hCAFE_0012;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd12;
    tick();
    idle_inputs();
    bus.ra[0] = 5'd12;
    bus.we[0] = 1'b1; bus.wa[0] = 5'd12; bus.wd[0] = 32'h1234_5678;
    #1;
`ifdef RF_BYPASS_EN
    tests_run++;
    if (bus.rd[0] !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL bypass_rd: got %h required %h", bus.rd[0], 32'h1234_5678);
    end
    tests_run++;
    if (bus.rbusy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_rbusy: got %b required 0", bus.rbusy[0]);
    end
`else
    tests_run++;
    if (bus.rd[0] !== 32'hCAFE_0012) begin
      tests_failed++;
      $display("FAIL nobypass_rd: got %h required %h", bus.rd[0], 32'hCAFE_0012);
    end
    tests_run++;
    if (bus.rbusy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL nobypass_rbusy: got %b required 1", bus.rbusy[0]);
    end
`endif
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (bus.rd[0] !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL bypass_next: got %h required %h", bus.rd[0], 32'h1234_5678);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      bus.we = 2'b11;
      bus.wa[0] = 5'(2 * k + 1); bus.wd[0] = 32'(2 * k + 1) * 32'h1111;
      bus.wa[1] = 5'(2 * k + 2); bus.wd[1] = 32'(2 * k + 2) * 32'h1111;
      if (k == 2) bus.we[1] = 1'b0;
      bus.alloc_en = 1'b1; bus.alloc_addr = 5'd6;
      tick();
    end
    idle_inputs();
    bus.ra[0] = 5'd2;
    bus.ra[1] = 5'd6;
    #1;
    tests_run++;
    if (bus.rd[0] !== 32'h2222 || bus.rbusy[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_setup: got rd2=%h busy6=%b required 00002222/1", bus.rd[0], bus.rbusy[1]);
    end
    reset = 1'b1;
    bus.we[0] = 1'b1; bus.wa[0] = 5'd2; bus.wd[0] = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    idle_inputs();
    for (int a = 1; a <= 6; a++) begin
      bus.ra[0] = 5'(a);
      bus.ra[1] = 5'(a + 6);
      #1;
      tests_run++;
      if (bus.rd[0] !== 32'h0 || bus.rbusy[0] !== 1'b0 || bus.rd[1] !== 32'h0 || bus.rbusy[1] !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_reset a=%0d: got rd=%h/%h busy=%b/%b required all zero",
                 a, bus.rd[0], bus.rd[1], bus.rbusy[0], bus.rbusy[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < NW; j++) begin
        bus.we[j] = 1'($urandom_range(0, 1));
        bus.wa[j] = 5'($urandom_range(0, 7));
        bus.wd[j] = $urandom;
      end
      bus.alloc_en   = 1'($urandom_range(0, 1));
      bus.alloc_addr = 5'($urandom_range(0, 7));
      for (int i = 0; i < NR; i++) bus.ra[i] = 5'($urandom_range(0, 8));
      reset = ($urandom_range(0, 39) == 0);
      #1;
      for (int i = 0; i < NR; i++) begin
        tests_run++;
        if (bus.rd[i] !== exp_rd(i) || bus.rbusy[i] !== exp_busy(i)) begin
          tests_failed++;
          $display("FAIL random n=%0d port=%0d ra=%0d: got rd=%h busy=%b required rd=%h busy=%b",
                   n, i, bus.ra[i], bus.rd[i], bus.rbusy[i], exp_rd(i), exp_busy(i));
        end
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    bus.ra = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read RISC-V register file.
- Configurable data width, register count, read-port count and write-port count.
- Adds synchronous reset, write-port collision priority and a per-register busy scoreboard for pending writebacks.
- Sits between decode (read addresses, allocation) and writeback (write ports) in the core datapath.

Parameters:
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers (power of two, >= 2).
- NR, 2: number of read ports (>= 1).
- NW, 1: number of write ports (>= 1).
- AW, $clog2(NREGS): address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  NW  per-port write enable.
- wa  in  NW x AW  per-port write address.
- wd  in  NW x XLEN  per-port write data.
- ra  in  NR x AW  per-port read address.
- rd  out  NR x XLEN  per-port read data.
- rbusy  out  NR  per-port: addressed register has a pending write.
- alloc_en  in  1  mark destination register pending (issue of a writing instruction).
- alloc_addr  in  AW  register to mark pending.

Behaviour:
- Storage: NREGS x XLEN flops. Register 0 is hardwired zero: reads return 0, writes are ignored, it is never busy, and allocations to it are ignored.
- Reads: combinational, zero latency. rd[i] = regs[ra[i]]. Reading during reset returns the current (pre-clear) contents until the edge.
- Writes: on a rising edge with we[j]=1 and wa[j]!=0, regs[wa[j]] <= wd[j]; the value is visible on rd in the next cycle.
- Write collision: if several ports target the same address in one cycle, the highest port index wins. Writes to different addresses all commit.
- Scoreboard: busy[NREGS] bit vector.
  - alloc_en=1 with alloc_addr!=0 sets busy[alloc_addr] at the edge.
  - Any committed write to address a clears busy[a] at the edge.
  - Alloc and write to the same address in the same cycle: busy ends set (the new producer wins).
  - Alloc to an already-busy register: stays set; there is no count, only a single pending producer per register.
- rbusy[i] = busy[ra[i]], subject to the optional bypass below. rbusy for address 0 is always 0.
- Reset: when reset=1 at an edge, all regs <= 0 and all busy <= 0. Reset overrides same-cycle writes and allocs.
  - After reset, all rd = 0 and all rbusy = 0.
  - Reset asserted mid-stream discards in-flight writes; pending writebacks arriving after reset simply write (busy is already 0).
- Outputs are never X after the first reset edge. Behaviour before the first reset is undefined.

Optional Feature:
- Macro RF_BYPASS_EN.
- When defined: same-cycle write-to-read forwarding.
  - If any we[j]=1, wa[j]=ra[i] and ra[i]!=0, then rd[i]=wd[j], using the highest matching j.
  - rbusy[i] is forced to 0 for that port in that cycle.
- When undefined: rd returns the pre-edge stored value and rbusy reflects the stored busy bit. The written value appears one cycle later.
- Combinational path wd->rd exists only with the macro defined.

Decomposition:
- Package rf_pkg holds:
  - default XLEN/NREGS constants;
  - a typedef for the register index (logic [AW-1:0]) and for the XLEN word;
  - the constant REG_ZERO = 0.
- One sub-module: rf_scoreboard (busy vector, alloc/clear priority, reset). regfile_mp instantiates it and keeps storage, collision resolution and read muxing.

Test Plan:
- Reset then read: assert reset 1 cycle; ra = {1,31} -> rd = {0,0}, rbusy = {0,0}.
- Basic write/read: write port 0: we=1, wa=5, wd=32'h0000_5555; next cycle ra[0]=5 -> rd[0]=32'h0000_5555. Write wa=0, wd=32'hFFFF_FFFF; ra[1]=0 -> rd[1]=0.
- Collision (NW=2): same cycle wa={7,7}, wd={32'hAAAA_AAAA, 32'hBBBB_BBBB} -> next cycle rd(7)=32'hBBBB_BBBB. Different addresses {3,4} -> both committed.
- Scoreboard:
  - alloc_en=1, alloc_addr=9 -> next cycle rbusy for ra=9 is 1.
  - Write wa=9 -> busy cleared the following cycle.
  - Alloc 9 and write 9 in the same cycle -> busy stays 1.
  - Alloc 0 -> rbusy(0)=0.
- Bypass: write wa=12, wd=32'h1234_5678 while ra[0]=12.
  - With RF_BYPASS_EN: same-cycle rd[0]=32'h1234_5678, rbusy[0]=0.
  - Without it: rd[0]=previous value, new value appears the next cycle.
- Reset mid-operation: regs 1..5 hold i*32'h1111 and reg 6 is busy; assert reset in the same cycle as a write to 2 -> all rd=0, all rbusy=0, and the write to 2 is discarded.
